// File: rtl/blk8_pkg.sv
// Shared constants, state encoding and address helper for the 8x8 block scan controller.
package blk8_pkg;

  localparam int BLK_DIM  = 8;
  localparam int BLK_PIX  = 64;
  localparam int BLK_LOG2 = 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_SCAN = S_SCAN,
    ST_DONE = S_DONE
  } state_t;

  // Raster address of pixel pix inside block (tx, ty), computed at 32 bits.
  function automatic logic [31:0] blk_addr(input int unsigned img_w,
                                           input logic [7:0] ty,
                                           input logic [7:0] tx,
                                           input logic [5:0] pix);
    logic [31:0] row;
    logic [31:0] col;
    row = ({24'd0, ty} << BLK_LOG2) + {29'd0, pix[5:3]};
    col = ({24'd0, tx} << BLK_LOG2) + {29'd0, pix[2:0]};
    return row * img_w + col;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with clear and enable; wrap flags the terminal count.
module wrap_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= wrap ? '0 : r_count + WIDTH'(1);
    end
  end

  assign count = r_count;
  assign wrap  = (r_count == WIDTH'(MAX));

endmodule

// File: rtl/blk8_scan_ctrl.sv
// Frame sequencer: emits raster pixel addresses block by block on a valid/ready stream.
module blk8_scan_ctrl
  import blk8_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              blk_first,
  output logic              blk_last,
  output logic [7:0]        tile_x,
  output logic [7:0]        tile_y,
  output logic              busy,
  output logic              frame_done
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_valid;
  logic              r_first;
  logic              r_last;
  logic              r_busy;
  logic              r_done;

  logic [5:0]        w_pix;
  logic [7:0]        w_tx;
  logic [7:0]        w_ty;
  logic              w_pix_wrap;
  logic              w_tx_wrap;
  logic              w_ty_wrap;
  logic              w_beat;
  logic              w_clr;
  logic              w_tx_en;
  logic              w_ty_en;
  logic              w_last_beat;
  logic [5:0]        w_pix_nxt;
  logic [7:0]        w_tx_nxt;
  logic [7:0]        w_ty_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;

  assign w_beat      = (r_state == ST_SCAN) && addr_ready;
  assign w_clr       = (r_state == ST_IDLE) && start;
  assign w_tx_en     = w_beat && w_pix_wrap;
  assign w_ty_en     = w_tx_en && w_tx_wrap;
  assign w_last_beat = w_ty_en && w_ty_wrap;

  wrap_counter #(.WIDTH(6), .MAX(BLK_PIX - 1)) u_pix_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .en    (w_beat),
    .count (w_pix),
    .wrap  (w_pix_wrap)
  );

  wrap_counter #(.WIDTH(8), .MAX(IMG_W / BLK_DIM - 1)) u_tx_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .en    (w_tx_en),
    .count (w_tx),
    .wrap  (w_tx_wrap)
  );

  wrap_counter #(.WIDTH(8), .MAX(IMG_H / BLK_DIM - 1)) u_ty_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .en    (w_ty_en),
    .count (w_ty),
    .wrap  (w_ty_wrap)
  );

  // Mirror the counters' next values so addr/flags register in step with them.
  always_comb begin
    w_pix_nxt = w_pix;
    w_tx_nxt  = w_tx;
    w_ty_nxt  = w_ty;
    if (w_clr) begin
      w_pix_nxt = '0;
      w_tx_nxt  = '0;
      w_ty_nxt  = '0;
    end else begin
      if (w_beat)  w_pix_nxt = w_pix_wrap ? 6'd0 : w_pix + 6'd1;
      if (w_tx_en) w_tx_nxt  = w_tx_wrap  ? 8'd0 : w_tx + 8'd1;
      if (w_ty_en) w_ty_nxt  = w_ty_wrap  ? 8'd0 : w_ty + 8'd1;
    end
  end

  assign w_addr_nxt = ADDR_W'(blk_addr(IMG_W, w_ty_nxt, w_tx_nxt, w_pix_nxt));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_addr <= w_addr_nxt;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SCAN;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_first <= 1'b1;
            r_last  <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (w_last_beat) begin
            r_state <= ST_DONE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_first <= (w_pix_nxt == 6'd0);
            r_last  <= (w_pix_nxt == 6'(BLK_PIX - 1));
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign addr       = r_addr;
  assign addr_valid = r_valid;
  assign blk_first  = r_first;
  assign blk_last   = r_last;
  assign tile_x     = w_tx;
  assign tile_y     = w_ty;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_blk8_scan_ctrl.sv
// Self-checking bench for blk8_scan_ctrl: beat scoreboard plus table and corner-case sequences.
module tb_blk8_scan_ctrl;

  localparam int IMG_W  = 16;
  localparam int IMG_H  = 16;
  localparam int ADDR_W = 8;
  localparam int NBEATS = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic              addr_ready;
  logic              blk_first;
  logic              blk_last;
  logic [7:0]        tile_x;
  logic [7:0]        tile_y;
  logic              busy;
  logic              frame_done;

  blk8_scan_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .addr       (addr),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .blk_first  (blk_first),
    .blk_last   (blk_last),
    .tile_x     (tile_x),
    .tile_y     (tile_y),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] tx;
    logic [7:0] ty;
    logic       first;
    logic       last;
  } beat_t;

  typedef struct {
    int    beat;
    beat_t exp;
  } vec_t;

  beat_t sb_q[$];
  beat_t cap [NBEATS];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    beat_cnt = 0;
  int    done_cnt = 0;
  int    cyc      = 0;
  int    last_cyc = 0;
  int    done_cyc = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference beat order built from nested image loops.
  task automatic push_frame();
    beat_t b;
    for (int ty = 0; ty < IMG_H / 8; ty++)
      for (int tx = 0; tx < IMG_W / 8; tx++)
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++) begin
            b.addr  = 8'((ty * 8 + r) * IMG_W + tx * 8 + c);
            b.tx    = 8'(tx);
            b.ty    = 8'(ty);
            b.first = (r == 0 && c == 0);
            b.last  = (r == 7 && c == 7);
            sb_q.push_back(b);
          end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every accepted beat is popped from the scoreboard and compared.
  initial forever begin
    beat_t got;
    beat_t exp;
    @(negedge clk);
    if (rst && addr_valid && addr_ready) begin
      got = {addr, tile_x, tile_y, blk_first, blk_last};
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_beat: unexpected beat addr %0d, scoreboard empty", addr);
      end else begin
        exp = sb_q.pop_front();
        chk($sformatf("sb_beat%0d", beat_cnt), 64'(got), 64'(exp));
      end
      if (beat_cnt < NBEATS) cap[beat_cnt] = got;
      beat_cnt++;
      last_cyc = cyc;
    end
    if (frame_done) done_cnt++;
  end

  task automatic start_frame(input string name);
    beat_cnt = 0;
    done_cnt = 0;
    push_frame();
    chk({name, "_prestart_valid"}, 64'(addr_valid), 64'd0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, "_start_latency"}, 64'(addr_valid), 64'd1);
  endtask

  task automatic run_to_done(input string name, input int budget, input bit rnd, input bit spam);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (frame_done) begin
        found    = 1'b1;
        done_cyc = cyc;
        break;
      end
      if (rnd)  addr_ready = 1'($urandom_range(0, 1));
      if (spam) start = (i % 37 == 5);
    end
    start      = 1'b0;
    addr_ready = 1'b1;
    if (!found) begin
      n_checks++;
      $display("FAIL %s_timeout: no frame_done within %0d cycles", name, budget);
    end
  endtask

  task automatic finish_frame(input string name);
    chk({name, "_done_after_last"}, 64'(done_cyc), 64'(last_cyc + 1));
    @(posedge clk); #1;
    chk({name, "_done_width"}, 64'(frame_done), 64'd0);
    chk({name, "_idle_busy"}, 64'(busy), 64'd0);
    chk({name, "_beats"}, 64'(beat_cnt), 64'(NBEATS));
    chk({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({name, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    vec_t vecs[8];
    vecs[0] = '{0,   '{8'd0,   8'd0, 8'd0, 1'b1, 1'b0}};
    vecs[1] = '{1,   '{8'd1,   8'd0, 8'd0, 1'b0, 1'b0}};
    vecs[2] = '{7,   '{8'd7,   8'd0, 8'd0, 1'b0, 1'b0}};
    vecs[3] = '{8,   '{8'd16,  8'd0, 8'd0, 1'b0, 1'b0}};
    vecs[4] = '{63,  '{8'd119, 8'd0, 8'd0, 1'b0, 1'b1}};
    vecs[5] = '{64,  '{8'd8,   8'd1, 8'd0, 1'b1, 1'b0}};
    vecs[6] = '{128, '{8'd128, 8'd0, 8'd1, 1'b1, 1'b0}};
    vecs[7] = '{255, '{8'd255, 8'd1, 8'd1, 1'b0, 1'b1}};

    rst = 1'b0; start = 1'b0; addr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 64'(addr_valid), 64'd0);
    chk("reset_addr", 64'(addr), 64'd0);
    rst = 1'b1;

    // Idle without start.
    repeat (5) @(posedge clk);
    #1;
    chk("idle_valid", 64'(addr_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_addr", 64'(addr), 64'd0);
    chk("idle_flags", 64'({blk_first, blk_last}), 64'd0);
    chk("idle_no_done", 64'(done_cnt), 64'd0);

    // Full frame with ready held high, then the boundary table.
    start_frame("f1");
    chk("f1_busy", 64'(busy), 64'd1);
    run_to_done("f1", 400, 1'b0, 1'b0);
    finish_frame("f1");
    for (int i = 0; i < 8; i++)
      chk($sformatf("vec_beat%0d", vecs[i].beat), 64'(cap[vecs[i].beat]), 64'(vecs[i].exp));

    // Backpressure at pix_idx 10 (addr 18).
    start_frame("bp");
    for (int i = 0; i < 100; i++) begin
      if (addr == 8'd18) break;
      @(posedge clk); #1;
    end
    addr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", k), 64'({addr_valid, addr, blk_first}), 64'({1'b1, 8'd18, 1'b0}));
    end
    addr_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_addr", 64'(addr), 64'd19);
    run_to_done("bp", 400, 1'b0, 1'b0);
    finish_frame("bp");

    // Start spam mid-scan and during DONE, then start in the first IDLE cycle.
    start_frame("spam");
    run_to_done("spam", 400, 1'b0, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    chk("spam_done_start_ignored", 64'(addr_valid), 64'd0);
    chk("spam_beats", 64'(beat_cnt), 64'(NBEATS));
    chk("spam_done_cnt", 64'(done_cnt), 64'd1);
    chk("spam_sb_empty", 64'(sb_q.size()), 64'd0);
    beat_cnt = 0;
    done_cnt = 0;
    push_frame();
    @(posedge clk); #1;
    start = 1'b0;
    chk("f2_idle_start_latency", 64'(addr_valid), 64'd1);
    run_to_done("f2", 400, 1'b0, 1'b0);
    finish_frame("f2");
    chk("f2_first_addr", 64'(cap[0].addr), 64'd0);

    // Reset mid-scan at beat 100.
    start_frame("rs");
    for (int i = 0; i < 200; i++) begin
      if (beat_cnt >= 100) break;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    addr_ready = 1'b0;
    @(posedge clk); #1;
    chk("rs_valid", 64'(addr_valid), 64'd0);
    chk("rs_busy", 64'(busy), 64'd0);
    chk("rs_addr", 64'(addr), 64'd0);
    sb_q.delete();
    rst = 1'b1;
    addr_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rs_no_done", 64'(done_cnt), 64'd0);
    chk("rs_stays_idle", 64'(addr_valid), 64'd0);
    start_frame("rs2");
    run_to_done("rs2", 400, 1'b0, 1'b0);
    finish_frame("rs2");
    chk("rs2_first_addr", 64'(cap[0].addr), 64'd0);

    // Random backpressure over a full frame.
    start_frame("rnd");
    run_to_done("rnd", 3000, 1'b1, 1'b0);
    finish_frame("rnd");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
